// File: rtl/tl_a_rr_arbiter.sv
// Round-robin arbiter merging N TileLink A-channel clients onto one manager port.
// Grants are held across back-pressure (HOLD) and locked for multi-beat Put bursts (BURST).
module tl_a_rr_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int SOURCE_W  = 4,
  parameter int IDX_W     = $clog2(N_CLIENTS),
  localparam int M_SOURCE_W = SOURCE_W + IDX_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_CLIENTS-1:0]          cli_a_valid_i,
  output logic [N_CLIENTS-1:0]          cli_a_ready_o,
  input  logic [N_CLIENTS*3-1:0]        cli_a_opcode_i,
  input  logic [N_CLIENTS*3-1:0]        cli_a_param_i,
  input  logic [N_CLIENTS*4-1:0]        cli_a_size_i,
  input  logic [N_CLIENTS*SOURCE_W-1:0] cli_a_source_i,
  input  logic [N_CLIENTS*ADDR_W-1:0]   cli_a_address_i,
  input  logic [N_CLIENTS*8-1:0]        cli_a_mask_i,
  input  logic [N_CLIENTS*DATA_W-1:0]   cli_a_data_i,
  input  logic [N_CLIENTS-1:0]          cli_a_corrupt_i,
  output logic                          mgr_a_valid_o,
  input  logic                          mgr_a_ready_i,
  output logic [2:0]                    mgr_a_opcode_o,
  output logic [2:0]                    mgr_a_param_o,
  output logic [3:0]                    mgr_a_size_o,
  output logic [M_SOURCE_W-1:0]         mgr_a_source_o,
  output logic [ADDR_W-1:0]             mgr_a_address_o,
  output logic [7:0]                    mgr_a_mask_o,
  output logic [DATA_W-1:0]             mgr_a_data_o,
  output logic                          mgr_a_corrupt_o,
  output logic [IDX_W-1:0]              grant_idx_o,
  output logic                          busy_o
);

  // Handshake: a beat transfers on any rising edge where mgr_a_valid_o && mgr_a_ready_i;
  // the same cycle cli_a_ready_o[grant_idx_o] mirrors mgr_a_ready_i for the selected client.

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, BURST = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [2:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0] win_idx;
  logic             any_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic             hs;
  logic             is_multi;
  logic [2:0]       beats_m1;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] g);
    if (int'(g) == N_CLIENTS - 1) return '0;
    return g + 1'b1;
  endfunction

  // Lowest offset from rr_ptr wins: scan downwards so the last hit is the nearest.
  always_comb begin
    int               c;
    logic [IDX_W-1:0] ci;
    win_idx   = rr_ptr_q;
    any_valid = 1'b0;
    c         = 0;
    ci        = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      c = int'(rr_ptr_q) + k;
      if (c >= N_CLIENTS) c = c - N_CLIENTS;
      ci = IDX_W'(c);
      if (cli_a_valid_i[ci]) begin
        win_idx   = ci;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx   = (state_q == IDLE) ? win_idx : grant_q;
    sel_valid = (state_q == IDLE) ? any_valid : cli_a_valid_i[grant_q];
    hs        = sel_valid && mgr_a_ready_i;
  end

  always_comb begin
    mgr_a_opcode_o  = '0;
    mgr_a_param_o   = '0;
    mgr_a_size_o    = '0;
    mgr_a_source_o  = '0;
    mgr_a_address_o = '0;
    mgr_a_mask_o    = '0;
    mgr_a_data_o    = '0;
    mgr_a_corrupt_o = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        mgr_a_opcode_o  = cli_a_opcode_i[i*3 +: 3];
        mgr_a_param_o   = cli_a_param_i[i*3 +: 3];
        mgr_a_size_o    = cli_a_size_i[i*4 +: 4];
        mgr_a_source_o  = {IDX_W'(i), cli_a_source_i[i*SOURCE_W +: SOURCE_W]};
        mgr_a_address_o = cli_a_address_i[i*ADDR_W +: ADDR_W];
        mgr_a_mask_o    = cli_a_mask_i[i*8 +: 8];
        mgr_a_data_o    = cli_a_data_i[i*DATA_W +: DATA_W];
        mgr_a_corrupt_o = cli_a_corrupt_i[i];
      end
    end
  end

  // Counter holds beats still to go after the first, so 2^(size-3)-1 with size clamped to 6.
  always_comb begin
    is_multi = (mgr_a_opcode_o == 3'd0 || mgr_a_opcode_o == 3'd1) && (mgr_a_size_o > 4'd3);
    case ((mgr_a_size_o > 4'd6) ? 4'd6 : mgr_a_size_o)
      4'd4:    beats_m1 = 3'd1;
      4'd5:    beats_m1 = 3'd3;
      4'd6:    beats_m1 = 3'd7;
      default: beats_m1 = 3'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = win_idx;
          if (mgr_a_ready_i) begin
            rr_ptr_d = ptr_inc(win_idx);
            if (is_multi) begin
              cnt_d   = beats_m1;
              state_d = BURST;
            end
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (hs) begin
          rr_ptr_d = ptr_inc(grant_q);
          if (is_multi) begin
            cnt_d   = beats_m1;
            state_d = BURST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BURST: begin
        if (hs) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks the externally visible control outputs in the same cycle it is asserted.
  always_comb begin
    cli_a_ready_o = '0;
    if (rst_ni) cli_a_ready_o[sel_idx] = mgr_a_ready_i;
    mgr_a_valid_o = rst_ni && sel_valid;
    grant_idx_o   = rst_ni ? sel_idx : '0;
    busy_o        = rst_ni && (state_q != IDLE);
  end

endmodule

// File: tb/tb_tl_a_rr_arbiter.sv
// Directed bench for tl_a_rr_arbiter: round-robin order, bursts, hold, gaps, reset abort.
module tb_tl_a_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    cli_valid, cli_ready;
  logic [N*3-1:0]  cli_opcode, cli_param;
  logic [N*4-1:0]  cli_size;
  logic [N*SW-1:0] cli_source;
  logic [N*AW-1:0] cli_address;
  logic [N*8-1:0]  cli_mask;
  logic [N*DW-1:0] cli_data;
  logic [N-1:0]    cli_corrupt;
  logic            mgr_valid, mgr_ready, mgr_corrupt, busy;
  logic [2:0]      mgr_opcode, mgr_param;
  logic [3:0]      mgr_size;
  logic [SW+IW-1:0] mgr_source;
  logic [AW-1:0]   mgr_address;
  logic [7:0]      mgr_mask;
  logic [DW-1:0]   mgr_data;
  logic [IW-1:0]   grant_idx;

  int n_vec = 0;
  int n_err = 0;
  logic [IW-1:0] exp_q[$];

  tl_a_rr_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cli_a_valid_i(cli_valid), .cli_a_ready_o(cli_ready),
    .cli_a_opcode_i(cli_opcode), .cli_a_param_i(cli_param), .cli_a_size_i(cli_size),
    .cli_a_source_i(cli_source), .cli_a_address_i(cli_address), .cli_a_mask_i(cli_mask),
    .cli_a_data_i(cli_data), .cli_a_corrupt_i(cli_corrupt),
    .mgr_a_valid_o(mgr_valid), .mgr_a_ready_i(mgr_ready),
    .mgr_a_opcode_o(mgr_opcode), .mgr_a_param_o(mgr_param), .mgr_a_size_o(mgr_size),
    .mgr_a_source_o(mgr_source), .mgr_a_address_o(mgr_address), .mgr_a_mask_o(mgr_mask),
    .mgr_a_data_o(mgr_data), .mgr_a_corrupt_o(mgr_corrupt),
    .grant_idx_o(grant_idx), .busy_o(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cli(input int i, input logic v, input logic [2:0] op, input logic [3:0] sz);
    cli_valid[i]        = v;
    cli_opcode[i*3 +: 3] = op;
    cli_size[i*4 +: 4]   = sz;
  endtask

  task automatic check_grant(input string tag, input int i, input logic exp_busy);
    logic [N-1:0]     exp_rdy;
    logic [SW+IW-1:0] exp_src;
    exp_rdy = '0;
    if (mgr_ready) exp_rdy[i] = 1'b1;
    exp_src = {IW'(i), SW'(i + 5)};
    check({tag, "_valid"}, 64'(mgr_valid), 64'd1);
    check({tag, "_grant"}, 64'(grant_idx), 64'(i));
    check({tag, "_src"},   64'(mgr_source), 64'(exp_src));
    check({tag, "_addr"},  mgr_address, 64'h1000 * 64'(i + 1));
    check({tag, "_data"},  mgr_data, 64'hD0D0_0000_0000_0000 + 64'(i));
    check({tag, "_rdy"},   64'(cli_ready), 64'(exp_rdy));
    check({tag, "_busy"},  64'(busy), 64'(exp_busy));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(mgr_valid), 64'd0);
    check({tag, "_rdy"},   64'(cli_ready), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_grant"}, 64'(grant_idx), 64'd0);
  endtask

  initial begin
    cli_valid = '0; cli_opcode = '0; cli_param = '0; cli_size = '0;
    cli_source = '0; cli_address = '0; cli_mask = '0; cli_data = '0; cli_corrupt = '0;
    for (int i = 0; i < N; i++) begin
      cli_source[i*SW +: SW]  = SW'(i + 5);
      cli_address[i*AW +: AW] = 64'h1000 * 64'(i + 1);
      cli_mask[i*8 +: 8]      = 8'hF0 | 8'(i);
      cli_data[i*DW +: DW]    = 64'hD0D0_0000_0000_0000 + 64'(i);
    end
    rst_n = 1'b0;
    mgr_ready = 1'b1;
    for (int i = 0; i < N; i++) set_cli(i, 1'b1, 3'd4, 4'd2);

    // reset holds outputs low regardless of offered requests
    next_cycle(); #1;
    check_reset_outputs("reset");
    next_cycle();
    rst_n = 1'b1;

    // all clients Get, manager always ready: 0,1,2,3,0
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    while (exp_q.size() > 0) begin
      #1;
      check_grant("rr", int'(exp_q.pop_front()), 1'b0);
      next_cycle();
    end
    for (int i = 0; i < N; i++) set_cli(i, 1'b0, 3'd4, 4'd2);

    // move rr_ptr to 2 via a single grant of client 1
    set_cli(1, 1'b1, 3'd4, 4'd2);
    #1; check_grant("to_ptr2", 1, 1'b0);
    next_cycle();

    // client 2 PutFullData size 6: 8 beats, client 1 locked out, then granted
    set_cli(2, 1'b1, 3'd0, 4'd6);
    for (int k = 0; k < 8; k++) begin
      #1;
      check_grant("burst8", 2, k != 0);
      next_cycle();
    end
    set_cli(2, 1'b0, 3'd0, 4'd6);
    #1; check_grant("after_burst", 1, 1'b0);
    next_cycle();

    // client 1 held under back-pressure while client 0 competes
    mgr_ready = 1'b0;
    #1; check_grant("hold_c1", 1, 1'b0);
    next_cycle();
    set_cli(0, 1'b1, 3'd4, 4'd2);
    for (int k = 0; k < 2; k++) begin
      #1; check_grant("hold", 1, 1'b1);
      next_cycle();
    end
    mgr_ready = 1'b1;
    #1; check_grant("hold_hs", 1, 1'b1);
    next_cycle();
    // rr_ptr=2: client 3 must beat client 0
    set_cli(1, 1'b0, 3'd4, 4'd2);
    set_cli(3, 1'b1, 3'd4, 4'd2);
    #1; check_grant("ptr_after_hold", 3, 1'b0);
    next_cycle();
    set_cli(3, 1'b0, 3'd4, 4'd2);
    set_cli(0, 1'b0, 3'd4, 4'd2);

    // client 3 PutPartialData size 4 with a 2-cycle valid gap
    set_cli(3, 1'b1, 3'd1, 4'd4);
    #1; check_grant("pp_b1", 3, 1'b0);
    next_cycle();
    set_cli(3, 1'b0, 3'd1, 4'd4);
    set_cli(0, 1'b1, 3'd4, 4'd2);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("gap_valid", 64'(mgr_valid), 64'd0);
      check("gap_busy", 64'(busy), 64'd1);
      check("gap_grant", 64'(grant_idx), 64'd3);
      check("gap_c0_rdy", 64'(cli_ready[0]), 64'd0);
      next_cycle();
    end
    set_cli(3, 1'b1, 3'd1, 4'd4);
    #1; check_grant("pp_b2", 3, 1'b1);
    next_cycle();
    set_cli(3, 1'b0, 3'd1, 4'd4);
    #1; check_grant("pp_done", 0, 1'b0);
    next_cycle();

    // reset during beat 3 of an 8-beat burst from client 2 (rr_ptr=1)
    set_cli(2, 1'b1, 3'd0, 4'd6);
    for (int k = 0; k < 2; k++) begin
      #1; check_grant("rst_burst", 2, k != 0);
      next_cycle();
    end
    rst_n = 1'b0;
    #1; check_reset_outputs("mid_rst");
    next_cycle();
    rst_n = 1'b1;
    #1; check_grant("post_rst", 0, 1'b0);
    next_cycle();
    set_cli(0, 1'b0, 3'd4, 4'd2);
    set_cli(2, 1'b0, 3'd0, 4'd6);

    // AcquireBlock size 6 is single-beat
    set_cli(1, 1'b1, 3'd6, 4'd6);
    #1; check_grant("acq", 1, 1'b0);
    next_cycle();
    set_cli(1, 1'b0, 3'd6, 4'd6);
    #1;
    check("acq_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(mgr_valid), 64'd0);

    // PutFullData size 3 is single-beat
    set_cli(2, 1'b1, 3'd0, 4'd3);
    #1; check_grant("put8", 2, 1'b0);
    next_cycle();
    set_cli(2, 1'b0, 3'd0, 4'd3);
    #1; check("put8_busy", 64'(busy), 64'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
